// File: rtl/smooth_ctrl.sv
// Frame sequencer for the 3x3 smoothing datapath: drives the line-buffer shift enable,
// flushes the window after the last line and tracks output valid, coordinates and status.
module smooth_ctrl #(
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 1024,
  parameter int unsigned XW       = 11,
  parameter int unsigned YW       = 11,
  parameter int unsigned PIPE_LAT = 3
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          ifstart,
  input  logic          ivalid,
  output logic          buf_clken,
  output logic          pad_sel,
  output logic          odata_valid,
  output logic          oborder,
  output logic [XW-1:0] ox,
  output logic [YW-1:0] oy,
  output logic          oframe_done,
  output logic          oerr_restart,
  output logic          oerr_overrun,
  output logic          busy
);

  localparam int unsigned NumPix = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CW     = $clog2(NumPix + PIPE_LAT + 1);

  localparam logic [CW-1:0] CntPrimeEnd = CW'(H_ACTIVE);
  localparam logic [CW-1:0] CntRunEnd   = CW'(NumPix - 1);
  localparam logic [CW-1:0] CntFlushEnd = CW'(H_ACTIVE);
  localparam logic [CW-1:0] CntDrainEnd = CW'(PIPE_LAT - 1);
  localparam logic [XW-1:0] XMax        = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YMax        = YW'(V_ACTIVE - 1);

  typedef enum logic [2:0] {StIdle, StPrime, StRun, StFlush, StDrain} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [PIPE_LAT-1:0] vpipe_q, vpipe_d;
  logic [XW-1:0]       ox_d;
  logic [YW-1:0]       oy_d;
  logic                launch, restart, overrun, vld_next, border_d, done_d;

  // cnt_q holds the accepted-pixel index in PRIME/RUN, and the cycle index in FLUSH/DRAIN.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    buf_clken = 1'b0;
    pad_sel   = 1'b0;
    launch    = 1'b0;
    restart   = 1'b0;
    overrun   = 1'b0;
    if (ifstart) begin
      restart   = (state_q != StIdle);
      state_d   = StPrime;
      buf_clken = ivalid;
      cnt_d     = ivalid ? CW'(1) : '0;
    end else begin
      unique case (state_q)
        StIdle: ;
        StPrime: begin
          if (ivalid) begin
            buf_clken = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CntPrimeEnd) state_d = StRun;
          end
        end
        StRun: begin
          if (ivalid) begin
            buf_clken = 1'b1;
            launch    = 1'b1;
            cnt_d     = cnt_q + CW'(1);
            if (cnt_q == CntRunEnd) begin
              state_d = StFlush;
              cnt_d   = '0;
            end
          end
        end
        StFlush: begin
          buf_clken = 1'b1;
          pad_sel   = 1'b1;
          launch    = 1'b1;
          overrun   = ivalid;
          cnt_d     = cnt_q + CW'(1);
          if (cnt_q == CntFlushEnd) begin
            state_d = StDrain;
            cnt_d   = '0;
          end
        end
        StDrain: begin
          overrun = ivalid;
          cnt_d   = cnt_q + CW'(1);
          if (cnt_q == CntDrainEnd) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output coordinates name the next output; they advance once its valid has been shown.
  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = launch;
    for (int unsigned i = 1; i < PIPE_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
    ox_d = ox;
    oy_d = oy;
    if (odata_valid) begin
      if (ox == XMax) begin
        ox_d = '0;
        oy_d = (oy == YMax) ? '0 : oy + YW'(1);
      end else begin
        ox_d = ox + XW'(1);
      end
    end
    if (ifstart) begin
      vpipe_d = '0;
      ox_d    = '0;
      oy_d    = '0;
    end
    vld_next = vpipe_d[PIPE_LAT-1];
    border_d = vld_next & ((ox_d == '0) | (ox_d == XMax) | (oy_d == '0) | (oy_d == YMax));
    done_d   = vld_next & (ox_d == XMax) & (oy_d == YMax);
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      vpipe_q      <= '0;
      ox           <= '0;
      oy           <= '0;
      oborder      <= 1'b0;
      oframe_done  <= 1'b0;
      oerr_restart <= 1'b0;
      oerr_overrun <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      vpipe_q      <= vpipe_d;
      ox           <= ox_d;
      oy           <= oy_d;
      oborder      <= border_d;
      oframe_done  <= done_d;
      oerr_restart <= restart;
      oerr_overrun <= overrun;
    end
  end

  assign odata_valid = vpipe_q[PIPE_LAT-1];
  assign busy        = (state_q != StIdle);

endmodule

// File: tb/tb_smooth_ctrl.sv
// Scoreboard bench for smooth_ctrl: a tick/index model predicts each output and its arrival
// cycle; a second small instance covers the single-stage latency case.
module tb_smooth_ctrl;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int PL = 3;

  typedef struct {
    int due;
    int x;
    int y;
    bit brd;
    bit done;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ifstart = 1'b0;
  logic ivalid = 1'b0;
  logic buf_clken, pad_sel, odata_valid, oborder, oframe_done, oerr_restart, oerr_overrun, busy;
  logic [10:0] ox, oy;

  logic s_ifstart = 1'b0;
  logic s_ivalid = 1'b0;
  logic s_clken, s_pad, s_valid, s_border, s_done, s_erst, s_eovr, s_busy;
  logic [10:0] s_x, s_y;

  always #5 clk = ~clk;

  smooth_ctrl #(.H_ACTIVE(H), .V_ACTIVE(V), .XW(11), .YW(11), .PIPE_LAT(PL)) u_dut (
    .clk_in(clk), .rst(rst), .ifstart(ifstart), .ivalid(ivalid),
    .buf_clken(buf_clken), .pad_sel(pad_sel), .odata_valid(odata_valid), .oborder(oborder),
    .ox(ox), .oy(oy), .oframe_done(oframe_done), .oerr_restart(oerr_restart),
    .oerr_overrun(oerr_overrun), .busy(busy)
  );

  smooth_ctrl #(.H_ACTIVE(2), .V_ACTIVE(2), .XW(11), .YW(11), .PIPE_LAT(1)) u_dut_small (
    .clk_in(clk), .rst(rst), .ifstart(s_ifstart), .ivalid(s_ivalid),
    .buf_clken(s_clken), .pad_sel(s_pad), .odata_valid(s_valid), .oborder(s_border),
    .ox(s_x), .oy(s_y), .oframe_done(s_done), .oerr_restart(s_erst),
    .oerr_overrun(s_eovr), .busy(s_busy)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  exp_t q[$];
  exp_t qs[$];

  // Bench model: 0 idle, 1 accepting pixels, 2 padding, 3 draining.
  int m_mode = 0;
  int m_tick = 0;
  int m_pix = 0;
  int m_left = 0;

  bit n_ovr = 0, n_rst = 0, n_busy = 0;
  bit e_ovr = 0, e_rst = 0, e_busy = 0;

  int obs_clk, obs_pad, obs_val, obs_brd, obs_done, obs_ovr, obs_rst, obs_sval;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    e_ovr  <= n_ovr;
    e_rst  <= n_rst;
    e_busy <= n_busy;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clear_obs();
    obs_clk = 0; obs_pad = 0; obs_val = 0; obs_brd = 0;
    obs_done = 0; obs_ovr = 0; obs_rst = 0;
  endtask

  task automatic discard_after(input int c);
    exp_t tmp;
    while (q.size() > 0 && q[$].due > c) tmp = q.pop_back();
  endtask

  task automatic model_tick(input int c);
    exp_t e;
    int k;
    if (m_tick >= H + 1) begin
      k      = m_tick - (H + 1);
      e.due  = c + PL;
      e.x    = k % H;
      e.y    = k / H;
      e.brd  = (e.x == 0) || (e.x == H - 1) || (e.y == 0) || (e.y == V - 1);
      e.done = (k == H * V - 1);
      q.push_back(e);
    end
    m_tick++;
  endtask

  task automatic drive_cycle(input bit ifs, input bit iv);
    bit e_clk, e_pad, nov, nrs;
    int c;
    c = cyc;
    ifstart = ifs;
    ivalid  = iv;
    e_clk = 0; e_pad = 0; nov = 0; nrs = 0;
    if (ifs) begin
      nrs = (m_mode != 0);
      discard_after(c);
      m_mode = 1; m_tick = 0; m_pix = 0;
      if (iv) begin
        e_clk = 1; m_tick = 1; m_pix = 1;
      end
    end else begin
      case (m_mode)
        1: if (iv) begin
          e_clk = 1;
          model_tick(c);
          m_pix++;
          if (m_pix == H * V) begin m_mode = 2; m_left = H + 1; end
        end
        2: begin
          e_clk = 1; e_pad = 1; nov = iv;
          model_tick(c);
          m_left--;
          if (m_left == 0) begin m_mode = 3; m_left = PL; end
        end
        3: begin
          nov = iv;
          m_left--;
          if (m_left == 0) m_mode = 0;
        end
        default: ;
      endcase
    end
    #1;
    check_val("buf_clken", buf_clken, e_clk);
    check_val("pad_sel", pad_sel, e_pad);
    if (buf_clken) obs_clk++;
    if (pad_sel) obs_pad++;
    n_ovr  = nov;
    n_rst  = nrs;
    n_busy = (m_mode != 0);
    @(posedge clk);
    #1;
  endtask

  // Reset is applied with ifstart and ivalid high to show it overrides them.
  task automatic do_reset();
    rst = 1'b1; ifstart = 1'b1; ivalid = 1'b1;
    discard_after(cyc);
    m_mode = 0;
    n_ovr = 0; n_rst = 0; n_busy = 0;
    @(posedge clk);
    #1;
    rst = 1'b0; ifstart = 1'b0; ivalid = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_valid"}, odata_valid, 0);
    check_val({tag, "_border"}, oborder, 0);
    check_val({tag, "_ox"}, ox, 0);
    check_val({tag, "_oy"}, oy, 0);
    check_val({tag, "_done"}, oframe_done, 0);
    check_val({tag, "_erst"}, oerr_restart, 0);
    check_val({tag, "_eovr"}, oerr_overrun, 0);
    check_val({tag, "_busy"}, busy, 0);
  endtask

  task automatic check_frame(input string tag, input int val, input int brd, input int done);
    check_val({tag, "_valids"}, obs_val, val);
    check_val({tag, "_borders"}, obs_brd, brd);
    check_val({tag, "_frame_done"}, obs_done, done);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      check_val("busy", busy, e_busy);
      check_val("oerr_overrun", oerr_overrun, e_ovr);
      check_val("oerr_restart", oerr_restart, e_rst);
      if (oerr_overrun) obs_ovr++;
      if (oerr_restart) obs_rst++;
      if (odata_valid) begin
        obs_val++;
        if (oborder) obs_brd++;
        if (oframe_done) obs_done++;
        if (q.size() == 0) begin
          check_val("odata_valid", odata_valid, 0);
        end else begin
          e = q.pop_front();
          check_val("valid_cycle", cyc, e.due);
          check_val("ox", ox, e.x);
          check_val("oy", oy, e.y);
          check_val("oborder", oborder, e.brd);
          check_val("oframe_done", oframe_done, e.done);
        end
      end else begin
        if (q.size() > 0 && q[0].due <= cyc) begin
          e = q.pop_front();
          check_val("odata_valid", odata_valid, 1);
        end
        check_val("idle_flags", {oborder, oframe_done}, 0);
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (s_valid) begin
        obs_sval++;
        if (qs.size() == 0) begin
          check_val("small_valid", s_valid, 0);
        end else begin
          e = qs.pop_front();
          check_val("small_cycle", cyc, e.due);
          check_val("small_ox", s_x, e.x);
          check_val("small_oy", s_y, e.y);
          check_val("small_border", s_border, e.brd);
          check_val("small_done", s_done, e.done);
        end
      end else if (qs.size() > 0 && qs[0].due <= cyc) begin
        e = qs.pop_front();
        check_val("small_valid", s_valid, 1);
      end
    end
  end

  initial begin
    exp_t e;
    int c0;
    obs_sval = 0;
    clear_obs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    check_idle_outputs("reset");

    // Back-to-back frame.
    clear_obs();
    drive_cycle(1, 1);
    repeat (31) drive_cycle(0, 1);
    repeat (16) drive_cycle(0, 0);
    check_frame("b2b", 32, 20, 1);
    check_val("b2b_ticks", obs_clk, 41);
    check_val("b2b_pad", obs_pad, 9);

    // Gapped input.
    clear_obs();
    drive_cycle(1, 1);
    for (int i = 1; i < 32; i++) begin
      drive_cycle(0, 0);
      drive_cycle(0, 1);
    end
    repeat (16) drive_cycle(0, 0);
    check_frame("gap", 32, 20, 1);
    check_val("gap_ticks", obs_clk, 41);
    check_val("gap_pad", obs_pad, 9);

    // Restart at input pixel 13.
    drive_cycle(1, 1);
    repeat (12) drive_cycle(0, 1);
    drive_cycle(1, 1);
    clear_obs();
    repeat (31) drive_cycle(0, 1);
    repeat (16) drive_cycle(0, 0);
    check_frame("restart", 32, 20, 1);
    check_val("restart_pulses", obs_rst, 1);

    // Overrun: ivalid held through padding and drain, then two ignored idle cycles.
    clear_obs();
    drive_cycle(1, 1);
    repeat (31 + 12 + 2) drive_cycle(0, 1);
    repeat (10) drive_cycle(0, 0);
    check_frame("ovr", 32, 20, 1);
    check_val("ovr_pulses", obs_ovr, 12);
    check_val("ovr_ticks", obs_clk, 41);

    // Reset at pixel 20.
    drive_cycle(1, 1);
    repeat (19) drive_cycle(0, 1);
    do_reset();
    check_idle_outputs("midrst");
    clear_obs();
    repeat (4) drive_cycle(0, 1);
    repeat (4) drive_cycle(0, 0);
    check_val("midrst_ticks", obs_clk, 0);
    check_val("midrst_valids", obs_val, 0);

    // Single-stage latency, 2x2 frame: ticks 3..6 launch, valid one cycle later.
    c0 = cyc;
    for (int k = 0; k < 4; k++) begin
      e.due  = c0 + 4 + k;
      e.x    = k % 2;
      e.y    = k / 2;
      e.brd  = 1'b1;
      e.done = (k == 3);
      qs.push_back(e);
    end
    for (int i = 0; i < 12; i++) begin
      s_ifstart = (i == 0);
      s_ivalid  = (i < 4);
      drive_cycle(0, 0);
    end
    check_val("small_valids", obs_sval, 4);

    check_val("sb_pending", q.size(), 0);
    check_val("small_pending", qs.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
